// File: rtl/ps_serial_loader_if.sv
// Interface bundling the frame request, element phase words and the
// serial phase-shifter outputs of ps_serial_loader.
// master: the LUT-side driver (start, eout1..5) that observes the outputs.
// slave : the serial loader itself.
interface ps_serial_loader_if;
  logic       start;
  logic [4:0] eout1;
  logic [4:0] eout2;
  logic [4:0] eout3;
  logic [4:0] eout4;
  logic [4:0] eout5;
  logic       ps_sclk;
  logic       ps_sdata;
  logic       ps_le;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output start, eout1, eout2, eout3, eout4, eout5,
    input  ps_sclk, ps_sdata, ps_le, busy, done, overrun
  );

  modport slave (
    input  start, eout1, eout2, eout3, eout4, eout5,
    output ps_sclk, ps_sdata, ps_le, busy, done, overrun
  );
endinterface

// File: rtl/ps_serial_loader.sv
// ps_serial_loader: captures five 5-bit element phase words on a start
// request, shifts them MSB first (eout1 first) to daisy-chained
// phase-shifter drivers and then pulses a latch enable so every element
// updates together.
//
// Optional feature macro: PS_PARITY_EN
//   defined   -> an odd-parity bit follows each word's LSB (30-bit frame)
//   undefined -> plain 25-bit frame, no parity logic
//
// Bit window timing: each bit is held on ps_sdata for 2*CLK_DIV cycles;
// ps_sclk is low for the first CLK_DIV cycles and high for the rest, so
// data only changes while ps_sclk is low.
module ps_serial_loader #(
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  ps_serial_loader_if.slave    bus
);

  localparam int WORD_W = 5;
  localparam int NWORDS = 5;
`ifdef PS_PARITY_EN
  localparam int N = NWORDS * (WORD_W + 1);
`else
  localparam int N = NWORDS * WORD_W;
`endif
  localparam int BIT_W = $clog2(N + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LE_W  = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef PS_PARITY_EN
  // Odd parity: the returned bit makes the word plus parity hold an odd
  // number of ones.
  function automatic logic odd_parity(input logic [WORD_W-1:0] w);
    return ~(^w);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [N-1:0]     frame_s;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LE_W-1:0]  le_cnt_q, le_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             le_q, le_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Assemble the outgoing frame from the live element words (eout1 first).
  always_comb begin
`ifdef PS_PARITY_EN
    frame_s = {bus.eout1, odd_parity(bus.eout1),
               bus.eout2, odd_parity(bus.eout2),
               bus.eout3, odd_parity(bus.eout3),
               bus.eout4, odd_parity(bus.eout4),
               bus.eout5, odd_parity(bus.eout5)};
`else
    frame_s = {bus.eout1, bus.eout2, bus.eout3, bus.eout4, bus.eout5};
`endif
  end

  // Next-state and output logic for the IDLE/SHIFT/LATCH/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    le_cnt_d = le_cnt_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    le_d     = le_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Capture the whole frame now; bit 0 goes straight onto ps_sdata
          // and the remainder waits in the shift register.
          state_d = S_SHIFT;
          sdata_d = frame_s[N-1];
          shreg_d = {frame_s[N-2:0], 1'b0};
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
          sclk_d  = 1'b0;
          sdata_d = 1'b0;
          le_d    = 1'b0;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            // End of the low half: raise ps_sclk, data stays put.
            sclk_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // End of the last high half: park the serial lines and latch.
            state_d  = S_LATCH;
            sclk_d   = 1'b0;
            sdata_d  = 1'b0;
            le_d     = 1'b1;
            le_cnt_d = '0;
          end else begin
            // End of a high half: drop ps_sclk and present the next bit.
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b0;
            sdata_d = shreg_q[N-1];
            shreg_d = {shreg_q[N-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_LATCH: begin
        if (le_cnt_q == LE_LAST) begin
          state_d  = S_DONE;
          le_d     = 1'b0;
          done_d   = 1'b1;
          le_cnt_d = '0;
        end else begin
          le_cnt_d = le_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Counters are cleared on the way back to IDLE.
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        bit_d    = '0;
        div_d    = '0;
        le_cnt_d = '0;
        shreg_d  = '0;
      end

      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        sclk_d   = 1'b0;
        sdata_d  = 1'b0;
        le_d     = 1'b0;
        bit_d    = '0;
        div_d    = '0;
        le_cnt_d = '0;
        shreg_d  = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      le_cnt_q <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      le_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      le_cnt_q <= le_cnt_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      le_q     <= le_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ps_sclk  = sclk_q;
  assign bus.ps_sdata = sdata_q;
  assign bus.ps_le    = le_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  // overrun must flag the very cycle the stray start arrives, so it is a
  // gate of the registered busy flag with the live request.
  assign bus.overrun  = bus.start & busy_q;

endmodule

// File: tb/tb_ps_serial_loader.sv
// Self-checking bench for ps_serial_loader (CLK_DIV=4, LE_CYCLES=2).
// Cycle k is the cycle in which start is first driven high; outputs are
// sampled on the falling edge, inputs driven 1 time unit after rising edge.
module tb_ps_serial_loader;

`ifdef PS_PARITY_EN
  localparam int N      = 30;
  localparam int T_LE   = 241;
  localparam int T_DONE = 243;
`else
  localparam int N      = 25;
  localparam int T_LE   = 201;
  localparam int T_DONE = 203;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps_serial_loader_if bif();

  ps_serial_loader #(.CLK_DIV(4), .LE_CYCLES(2)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  e1;
    logic [4:0]  e2;
    logic [4:0]  e3;
    logic [4:0]  e4;
    logic [4:0]  e5;
    logic        chg3;
    logic [29:0] exp_stream;
  } vec_t;

  vec_t vecs [4];

  // monitor results of the last run_frame
  int          m_rises, m_first_rise, m_le_first, m_le_cnt, m_done;
  int          m_ovr_cnt, m_ovr_at, m_sdata_bad, m_busy1, m_busy_after, m_out_at_rst;
  logic [29:0] m_stream;

  task automatic run_frame(input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                           input logic [4:0] e4, input logic [4:0] e5, input logic chg3,
                           input int start_at, input int rst_at, input int max_c);
    logic prev_sclk;
    logic prev_sdata;
    @(posedge clk); #1;
    bif.eout1 = e1; bif.eout2 = e2; bif.eout3 = e3; bif.eout4 = e4; bif.eout5 = e5;
    bif.start = 1'b1;
    m_rises = 0; m_first_rise = -1; m_le_first = -1; m_le_cnt = 0; m_done = -1;
    m_ovr_cnt = 0; m_ovr_at = -1; m_sdata_bad = 0; m_busy1 = -1; m_busy_after = -1;
    m_out_at_rst = -1; m_stream = '0;
    prev_sclk = 1'b0; prev_sdata = 1'b0;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      if (bif.ps_sclk && !prev_sclk) begin
        m_rises++;
        if (m_first_rise < 0) m_first_rise = c;
        m_stream = {m_stream[28:0], bif.ps_sdata};
      end
      if (bif.ps_sclk && prev_sclk && (bif.ps_sdata !== prev_sdata)) m_sdata_bad++;
      if (bif.ps_le) begin
        if (m_le_first < 0) m_le_first = c;
        m_le_cnt++;
        if (bif.ps_sclk || bif.ps_sdata) m_sdata_bad++;
      end
      if (bif.overrun) begin m_ovr_cnt++; m_ovr_at = c; end
      if (c == 1) m_busy1 = int'(bif.busy);
      if (c == rst_at)
        m_out_at_rst = int'({bif.ps_sclk, bif.ps_sdata, bif.ps_le, bif.busy, bif.done, bif.overrun});
      if (bif.done && m_done < 0) m_done = c;
      if (m_done >= 0 && c == m_done + 1) begin
        m_busy_after = int'(bif.busy);
        break;
      end
      prev_sclk  = bif.ps_sclk;
      prev_sdata = bif.ps_sdata;
      @(posedge clk); #1;
      bif.start = (c + 1 == start_at);
      if (chg3 && (c + 1 == 3)) begin
        bif.eout1 = 5'h00; bif.eout2 = 5'h00; bif.eout3 = 5'h00; bif.eout4 = 5'h00; bif.eout5 = 5'h00;
      end
      if (c + 1 == rst_at) rst = 1'b1;
      if (c + 1 == rst_at + 2) rst = 1'b0;
    end
    bif.start = 1'b0;
  endtask

  initial begin
`ifdef PS_PARITY_EN
    vecs[0] = '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 30'b111110_000001_000001_000001_000001};
    vecs[1] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 1'b1, 30'b000010_000100_001000_010000_100000};
    vecs[2] = '{5'h15, 5'h0A, 5'h1B, 5'h04, 5'h11, 1'b0, 30'b101010_010101_110111_001000_100011};
    vecs[3] = '{5'h03, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 30'b000111_000001_000001_000001_000001};
`else
    vecs[0] = '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 30'b00000_11111_00000_00000_00000_00000};
    vecs[1] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 1'b1, 30'b00000_00001_00010_00100_01000_10000};
    vecs[2] = '{5'h15, 5'h0A, 5'h1B, 5'h04, 5'h11, 1'b0, 30'b00000_10101_01010_11011_00100_10001};
    vecs[3] = '{5'h03, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 30'b00000_00011_00000_00000_00000_00000};
`endif

    // reset state
    rst = 1'b1;
    bif.start = 1'b0;
    bif.eout1 = 5'h00; bif.eout2 = 5'h00; bif.eout3 = 5'h00; bif.eout4 = 5'h00; bif.eout5 = 5'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          int'({bif.ps_sclk, bif.ps_sdata, bif.ps_le, bif.busy, bif.done, bif.overrun}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4, vecs[v].e5, vecs[v].chg3, -1, -1, 400);
      check($sformatf("v%0d_rises", v),      m_rises, N);
      check($sformatf("v%0d_first_rise", v), m_first_rise, 5);
      check($sformatf("v%0d_stream", v),     int'(m_stream), int'(vecs[v].exp_stream));
      check($sformatf("v%0d_le_first", v),   m_le_first, T_LE);
      check($sformatf("v%0d_le_cycles", v),  m_le_cnt, 2);
      check($sformatf("v%0d_done_at", v),    m_done, T_DONE);
      check($sformatf("v%0d_busy_k1", v),    m_busy1, 1);
      check($sformatf("v%0d_busy_after", v), m_busy_after, 0);
      check($sformatf("v%0d_overrun", v),    m_ovr_cnt, 0);
      check($sformatf("v%0d_sdata_stable", v), m_sdata_bad, 0);
      repeat (2) @(posedge clk);
    end

    // stray start mid-frame: overrun for one cycle, frame unaffected
    run_frame(vecs[2].e1, vecs[2].e2, vecs[2].e3, vecs[2].e4, vecs[2].e5, 1'b0, 50, -1, 400);
    check("ovr_count",   m_ovr_cnt, 1);
    check("ovr_cycle",   m_ovr_at, 50);
    check("ovr_done_at", m_done, T_DONE);
    check("ovr_rises",   m_rises, N);
    check("ovr_stream",  int'(m_stream), int'(vecs[2].exp_stream));
    begin
      int busy_seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bif.busy) busy_seen++;
      end
      check("ovr_no_second_frame", busy_seen, 0);
    end

    // reset at k+100 aborts the frame with no latch pulse
    run_frame(5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 1'b0, -1, 100, 260);
    check("rst_busy_before", m_busy1, 1);
    check("rst_outputs",     m_out_at_rst, 0);
    check("rst_no_le",       m_le_cnt, 0);
    check("rst_no_done",     m_done, -1);
    run_frame(vecs[0].e1, vecs[0].e2, vecs[0].e3, vecs[0].e4, vecs[0].e5, 1'b0, -1, -1, 400);
    check("post_rst_rises",   m_rises, N);
    check("post_rst_stream",  int'(m_stream), int'(vecs[0].exp_stream));
    check("post_rst_done_at", m_done, T_DONE);
    repeat (2) @(posedge clk);

    // start held high: back-to-back frames, second one re-captures
    begin
      int done1 = -1, done2 = -1, busy_d1 = -1, busy_d2 = -1, ovr = 0, rises2 = 0;
      logic prev_sclk = 1'b0;
      logic [29:0] stream2 = '0;
      logic [29:0] exp2;
`ifdef PS_PARITY_EN
      exp2 = 30'b010101_101010_001000_110111_100011;
`else
      exp2 = 30'b00000_01010_10101_00100_11011_10001;
`endif
      @(posedge clk); #1;
      bif.eout1 = vecs[2].e1; bif.eout2 = vecs[2].e2; bif.eout3 = vecs[2].e3;
      bif.eout4 = vecs[2].e4; bif.eout5 = vecs[2].e5;
      bif.start = 1'b1;
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        if (bif.overrun) ovr++;
        if (done1 >= 0 && bif.ps_sclk && !prev_sclk) begin
          rises2++;
          stream2 = {stream2[28:0], bif.ps_sdata};
        end
        if (done1 >= 0 && c == done1 + 1) busy_d1 = int'(bif.busy);
        if (done1 >= 0 && c == done1 + 2) busy_d2 = int'(bif.busy);
        if (bif.done) begin
          if (done1 < 0) done1 = c;
          else if (done2 < 0) done2 = c;
        end
        if (done2 >= 0) break;
        prev_sclk = bif.ps_sclk;
        @(posedge clk); #1;
        if (c + 1 == 1) begin
          bif.eout1 = 5'h0A; bif.eout2 = 5'h15; bif.eout3 = 5'h04; bif.eout4 = 5'h1B; bif.eout5 = 5'h11;
        end
      end
      @(posedge clk); #1;
      bif.start = 1'b0;
      check("b2b_done1",       done1, T_DONE);
      check("b2b_busy_gap",    busy_d1, 0);
      check("b2b_busy_resume", busy_d2, 1);
      check("b2b_done2",       done2, 2 * T_DONE + 1);
      check("b2b_overrun_cnt", ovr, 2 * T_DONE);
      check("b2b_rises2",      rises2, N);
      check("b2b_stream2",     int'(stream2), int'(exp2));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
